fx2_cmd_port: RTL and testbench
===============================

Name: fx2_cmd_port

Overview:
Single-clock bridge between the FX2 synchronous slave-FIFO bus (IFCLK domain) and the byte-stream command/reply interface of the register manager. It pulls command bytes from the FX2 OUT endpoint and presents them as cmd_wr/cmd_in. It pushes reply bytes into the FX2 IN endpoint using the reply_rdy/reply_ack/reply_end handshake, and commits the short reply packet with PKTEND. It is the stage directly upstream (commands) and downstream (replies) of the register manager.

Parameters:
OUT_EP_ADDR, 2'b00, FIFOADR value selecting the FX2 OUT (host-to-device) endpoint
IN_EP_ADDR, 2'b10, FIFOADR value selecting the FX2 IN (device-to-host) endpoint

Ports:
clk  in  1  FX2 IFCLK; all logic on posedge
reset_n  in  1  asynchronous active-low reset
fx2_out_empty_n  in  1  low = OUT endpoint empty
fx2_in_full_n  in  1  low = IN endpoint full
fx2_fifoadr  out  2  endpoint select
fx2_sloe_n  out  1  FX2 output enable, active low
fx2_slrd_n  out  1  read strobe, active low
fx2_slwr_n  out  1  write strobe, active low
fx2_pktend_n  out  1  packet commit, active low
fx2_fd  inout  8  FX2 data bus
cmd_wr  out  1  one-cycle pulse: cmd_in valid
cmd_in  out  8  command byte, held until next cmd_wr
reply_out  in  8  reply byte from register manager
reply_rdy  in  1  reply byte available
reply_ack  out  1  reply byte consumed (one cycle)
reply_end  in  1  current reply byte is the last of its message

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset (asynchronous, immediate):
  - state=IDLE; all FX2 strobes =1; fx2_fd hi-Z.
  - fx2_fifoadr=OUT_EP_ADDR; cmd_wr=0, cmd_in=0, reply_ack=0; pktend-pending flag cleared.
  - Reset mid-transfer abandons the transfer. No strobe glitch is permitted.
- States: IDLE, RD_SETUP, RD, RD_GAP, WR_SETUP, WR, WR_GAP, PKTEND.
- IDLE:
  - Strobes inactive; fd hi-Z; sloe_n=1; fifoadr holds its last value.
  - If reply_rdy && fx2_in_full_n -> WR_SETUP.
  - Else if !reply_rdy && fx2_out_empty_n -> RD_SETUP.
  - Replies have priority.
- RD_SETUP: fifoadr=OUT_EP_ADDR, sloe_n=0; fd hi-Z; -> RD.
- RD:
  - slrd_n=0, sloe_n=0.
  - At the closing edge, fx2_fd is captured into cmd_in; -> RD_GAP.
- RD_GAP:
  - cmd_wr=1 for exactly this cycle; sloe_n=0.
  - If reply_rdy -> IDLE; else if fx2_out_empty_n -> RD; else -> IDLE.
  - Sustained read rate: one byte per 2 cycles.
- WR_SETUP: fifoadr=IN_EP_ADDR, sloe_n=1; fd still hi-Z (bus turnaround cycle); -> WR.
- WR:
  - fd driven with reply_out; slwr_n=0; reply_ack=1 (combinational from state).
  - If reply_end, set pktend-pending. -> WR_GAP.
- WR_GAP:
  - fd hi-Z; strobes inactive.
  - If pktend-pending -> PKTEND; else if reply_rdy && fx2_in_full_n -> WR; else -> IDLE.
- PKTEND: pktend_n=0 for one cycle, fifoadr=IN_EP_ADDR; clear pending; -> IDLE.
- fd is driven only in WR. sloe_n=0 only in RD_SETUP/RD/RD_GAP. The block never drives fd while sloe_n=0.
- Full/empty flags are sampled only at decision points (IDLE, RD_GAP, WR_GAP). A flag dropping after the strobe state is entered does not cancel that strobe.
- reply_rdy dropping mid-message: return to IDLE from WR_GAP. No ack is issued without reply_rdy.

Optional Feature:
FX2_CMD_PORT_PKTEND_EN
- Defined: reply messages are committed via the PKTEND state as above.
- Undefined: pktend-pending is never set; fx2_pktend_n is tied 1; WR_GAP never enters PKTEND. The host relies on FX2 auto-commit.

Test Plan:
1. Reset behaviour: assert reset_n=0 mid-RD -> same cycle: slrd_n=slwr_n=sloe_n=pktend_n=1, fd=Z, cmd_wr=0; after release, stays in IDLE with both flags low.
2. Command receive: out_empty_n=1, FD supplies AA 01 10 00 78 56 34 12 -> 8 cmd_wr pulses 2 cycles apart, with cmd_in matching each byte; fifoadr=OUT_EP_ADDR; sloe_n low throughout.
3. Reply transmit: reply_rdy=1 with reply_out 78,56,34,12, reply_end on 4th byte -> one turnaround cycle, then 4 slwr_n pulses with FD matching, 4 reply_ack pulses, then one pktend_n=0 cycle; fifoadr=IN_EP_ADDR.
4. Backpressure: in_full_n=0 after byte 2 for 10 cycles -> no slwr_n/reply_ack during stall; byte 3 (34) is written within 3 cycles of in_full_n=1.
5. Priority: reply_rdy=1 and out_empty_n=1 simultaneously in IDLE -> WR_SETUP taken, no slrd_n until the reply finishes.
6. Macro undefined: repeat scenario 3 -> identical writes, fx2_pktend_n constant 1.

Source files
------------

// File: rtl/fx2_cmd_port.sv
// fx2_cmd_port: FX2 slave-FIFO bridge feeding command bytes to, and draining reply bytes from, the register manager.
// Optional macro FX2_CMD_PORT_PKTEND_EN: commit every reply message with a PKTEND strobe after its last byte.
module fx2_cmd_port #(
    parameter logic [1:0] OUT_EP_ADDR = 2'b00,
    parameter logic [1:0] IN_EP_ADDR  = 2'b10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fx2_out_empty_n,
    input  logic       fx2_in_full_n,
    output logic [1:0] fx2_fifoadr,
    output logic       fx2_sloe_n,
    output logic       fx2_slrd_n,
    output logic       fx2_slwr_n,
    output logic       fx2_pktend_n,
    inout  wire  [7:0] fx2_fd,
    output logic       cmd_wr,
    output logic [7:0] cmd_in,
    input  logic [7:0] reply_out,
    input  logic       reply_rdy,
    output logic       reply_ack,
    input  logic       reply_end
);

`ifdef FX2_CMD_PORT_PKTEND_EN
    localparam logic PKTEND_EN = 1'b1;
`else
    localparam logic PKTEND_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD, RD_GAP, WR_SETUP, WR, WR_GAP, PKTEND
    } state_t;

    state_t     state_reg, state_next;
    logic       pend_reg, pend_next;
    logic [1:0] fifoadr_reg, fifoadr_next;
    logic [7:0] cmd_in_reg;
    logic       sloe_n_reg, slrd_n_reg, slwr_n_reg, pktend_n_reg;
    logic       cmd_wr_reg, ack_reg, fd_oe_reg;

    always_comb begin
        state_next   = state_reg;
        pend_next    = pend_reg;
        fifoadr_next = fifoadr_reg;
        case (state_reg)
            IDLE: begin
                if (reply_rdy && fx2_in_full_n)
                    state_next = WR_SETUP;
                else if (!reply_rdy && fx2_out_empty_n)
                    state_next = RD_SETUP;
            end
            RD_SETUP: state_next = RD;
            RD:       state_next = RD_GAP;
            RD_GAP: begin
                // A waiting reply always wins over the next command byte.
                if (!reply_rdy && fx2_out_empty_n)
                    state_next = RD;
                else
                    state_next = IDLE;
            end
            WR_SETUP: state_next = WR;
            WR: begin
                if (reply_end && PKTEND_EN)
                    pend_next = 1'b1;
                state_next = WR_GAP;
            end
            WR_GAP: begin
                if (pend_reg)
                    state_next = PKTEND;
                else if (reply_rdy && fx2_in_full_n)
                    state_next = WR;
                else
                    state_next = IDLE;
            end
            PKTEND: begin
                pend_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_next == RD_SETUP)
            fifoadr_next = OUT_EP_ADDR;
        if (state_next == WR_SETUP || state_next == PKTEND)
            fifoadr_next = IN_EP_ADDR;
    end

    // Strobes are decoded from the next state and registered so they never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            pend_reg     <= 1'b0;
            fifoadr_reg  <= OUT_EP_ADDR;
            cmd_in_reg   <= 8'h00;
            sloe_n_reg   <= 1'b1;
            slrd_n_reg   <= 1'b1;
            slwr_n_reg   <= 1'b1;
            pktend_n_reg <= 1'b1;
            cmd_wr_reg   <= 1'b0;
            ack_reg      <= 1'b0;
            fd_oe_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pend_reg     <= pend_next;
            fifoadr_reg  <= fifoadr_next;
            if (state_reg == RD)
                cmd_in_reg <= fx2_fd;
            sloe_n_reg   <= !(state_next inside {RD_SETUP, RD, RD_GAP});
            slrd_n_reg   <= (state_next != RD);
            slwr_n_reg   <= (state_next != WR);
            pktend_n_reg <= (state_next != PKTEND);
            cmd_wr_reg   <= (state_next == RD_GAP);
            ack_reg      <= (state_next == WR);
            fd_oe_reg    <= (state_next == WR);
        end
    end

    assign fx2_fd       = fd_oe_reg ? reply_out : 8'hzz;
    assign fx2_fifoadr  = fifoadr_reg;
    assign fx2_sloe_n   = sloe_n_reg;
    assign fx2_slrd_n   = slrd_n_reg;
    assign fx2_slwr_n   = slwr_n_reg;
    assign fx2_pktend_n = pktend_n_reg;
    assign cmd_wr       = cmd_wr_reg;
    assign cmd_in       = cmd_in_reg;
    assign reply_ack    = ack_reg;

endmodule

// File: tb/tb_fx2_cmd_port.sv
// tb_fx2_cmd_port: directed plus randomized bench with queue models of the FX2 endpoints and the register manager.
`timescale 1ns/1ps
module tb_fx2_cmd_port;
    localparam logic [1:0] OUT_EP = 2'b00;
    localparam logic [1:0] IN_EP  = 2'b10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       fx2_out_empty_n, fx2_in_full_n;
    logic [1:0] fx2_fifoadr;
    logic       fx2_sloe_n, fx2_slrd_n, fx2_slwr_n, fx2_pktend_n;
    wire  [7:0] fx2_fd;
    logic       cmd_wr;
    logic [7:0] cmd_in;
    logic [7:0] reply_out;
    logic       reply_rdy, reply_ack, reply_end;
    logic [7:0] fd_drv;

    fx2_cmd_port dut (
        .clk(clk), .reset_n(reset_n),
        .fx2_out_empty_n(fx2_out_empty_n), .fx2_in_full_n(fx2_in_full_n),
        .fx2_fifoadr(fx2_fifoadr), .fx2_sloe_n(fx2_sloe_n), .fx2_slrd_n(fx2_slrd_n),
        .fx2_slwr_n(fx2_slwr_n), .fx2_pktend_n(fx2_pktend_n), .fx2_fd(fx2_fd),
        .cmd_wr(cmd_wr), .cmd_in(cmd_in), .reply_out(reply_out),
        .reply_rdy(reply_rdy), .reply_ack(reply_ack), .reply_end(reply_end)
    );

    // FX2 drives the bus whenever its output enable is asserted.
    assign fx2_fd = fx2_sloe_n ? 8'hzz : fd_drv;

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] d; logic last;} rb_t;

    logic [7:0] out_q[$];      // FX2 OUT endpoint contents
    logic [7:0] exp_cmd[$];    // command bytes still owed to the register manager
    rb_t        rep_q[$];      // register manager's pending reply bytes
    rb_t        exp_wr[$];     // bytes still owed to the IN endpoint
    logic       rdy_en = 1'b1;

    int n_vec = 0, n_err = 0;
    int cyc = 0, full_low = 0, pk_age = 0;
    int n_rd = 0, n_wr = 0, n_pk = 0;
    logic rd_prev = 1'b0, wr_prev = 1'b0, need_pk = 1'b0;
    int cmd_cyc_q[$], rd_cyc_q[$], wr_cyc_q[$], pk_cyc_q[$], sloe_hi_q[$];
    logic [7:0] got_cmd[$], got_wr[$];

    logic [7:0] t2_lit [8] = '{8'hAA, 8'h01, 8'h10, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] t3_lit [4] = '{8'h78, 8'h56, 8'h34, 8'h12};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        fx2_out_empty_n = (out_q.size() != 0);
        fd_drv          = (out_q.size() != 0) ? out_q[0] : 8'h00;
        reply_rdy       = rdy_en && (rep_q.size() != 0);
        reply_out       = (rep_q.size() != 0) ? rep_q[0].d : 8'h00;
        reply_end       = (rep_q.size() != 0) ? rep_q[0].last : 1'b0;
    endtask

    task automatic push_cmd(input logic [7:0] b);
        out_q.push_back(b);
        exp_cmd.push_back(b);
        drive_inputs();
    endtask

    task automatic push_rep(input logic [7:0] b, input logic last);
        rb_t e;
        e.d = b;
        e.last = last;
        rep_q.push_back(e);
        exp_wr.push_back(e);
        drive_inputs();
    endtask

    task automatic clear_log();
        cmd_cyc_q.delete(); rd_cyc_q.delete(); wr_cyc_q.delete();
        pk_cyc_q.delete(); sloe_hi_q.delete(); got_cmd.delete(); got_wr.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name, input int maxc);
        int k = 0;
        while ((out_q.size() != 0 || rep_q.size() != 0 || exp_cmd.size() != 0 ||
                exp_wr.size() != 0 || need_pk) && k < maxc) begin
            tick();
            k++;
        end
        chk(name, (out_q.size() + rep_q.size() + exp_cmd.size() + exp_wr.size() + 32'(need_pk)), 0);
        repeat (4) tick();
    endtask

    // Monitor: advances the endpoint/manager models and checks every cycle.
    initial begin
        rb_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("rst_slrd", fx2_slrd_n, 1);
                chk("rst_slwr", fx2_slwr_n, 1);
                chk("rst_sloe", fx2_sloe_n, 1);
                chk("rst_pktend", fx2_pktend_n, 1);
                chk("rst_cmd_wr", cmd_wr, 0);
                chk("rst_ack", reply_ack, 0);
                chk("rst_fifoadr", fx2_fifoadr, OUT_EP);
                rd_prev = 1'b0;
                wr_prev = 1'b0;
            end else begin
                if (rd_prev && out_q.size() != 0) void'(out_q.pop_front());
                if (wr_prev && rep_q.size() != 0) void'(rep_q.pop_front());
                drive_inputs();
                if (fx2_in_full_n) full_low = 0; else full_low++;

                if (cmd_wr || rd_prev) chk("cmd_wr_after_rd", cmd_wr, rd_prev);
                if (cmd_wr) begin
                    cmd_cyc_q.push_back(cyc);
                    got_cmd.push_back(cmd_in);
                    chk("cmd_expected", exp_cmd.size() != 0, 1);
                    if (exp_cmd.size() != 0) chk("cmd_in", cmd_in, exp_cmd.pop_front());
                end
                if (!fx2_slrd_n) begin
                    n_rd++;
                    rd_cyc_q.push_back(cyc);
                    chk("rd_fifoadr", fx2_fifoadr, OUT_EP);
                    chk("rd_sloe", fx2_sloe_n, 0);
                end
                if (fx2_sloe_n) sloe_hi_q.push_back(cyc);
                chk("ack_eq_wr", reply_ack, !fx2_slwr_n);

`ifdef FX2_CMD_PORT_PKTEND_EN
                if (need_pk) pk_age++;
                if (!fx2_pktend_n) begin
                    n_pk++;
                    pk_cyc_q.push_back(cyc);
                    chk("pktend_expected", need_pk, 1);
                    chk("pktend_delay", pk_age, 2);
                    chk("pktend_fifoadr", fx2_fifoadr, IN_EP);
                    need_pk = 1'b0;
                end else if (need_pk) begin
                    chk("pktend_late", pk_age >= 2, 0);
                    if (pk_age >= 2) need_pk = 1'b0;
                end
`else
                chk("pktend_tied", fx2_pktend_n, 1);
`endif

                if (!fx2_slwr_n) begin
                    n_wr++;
                    wr_cyc_q.push_back(cyc);
                    got_wr.push_back(fx2_fd);
                    chk("wr_sloe", fx2_sloe_n, 1);
                    chk("wr_fifoadr", fx2_fifoadr, IN_EP);
                    chk("wr_rdy", reply_rdy, 1);
                    chk("wr_while_full", full_low >= 3, 0);
                    chk("wr_before_pktend", need_pk, 0);
                    chk("wr_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) begin
                        e = exp_wr.pop_front();
                        chk("fd_data", fx2_fd, e.d);
`ifdef FX2_CMD_PORT_PKTEND_EN
                        if (e.last) begin
                            need_pk = 1'b1;
                            pk_age = 0;
                        end
`endif
                    end
                end
                rd_prev = !fx2_slrd_n;
                wr_prev = !fx2_slwr_n;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r, base, k, cnt;
        logic was_wr;
        fx2_in_full_n = 1'b1;
        drive_inputs();

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        chk("init_fifoadr", fx2_fifoadr, OUT_EP);
        chk("init_strobes", {fx2_sloe_n, fx2_slrd_n, fx2_slwr_n, fx2_pktend_n}, 4'hF);
        chk("init_cmd_in", cmd_in, 0);
        chk("init_cmd_wr", cmd_wr, 0);
        chk("init_ack", reply_ack, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // Command receive: streaming read at one byte every two cycles
        clear_log();
        for (int i = 0; i < 8; i++) push_cmd(t2_lit[i]);
        drain("t2_drain", 100);
        chk("t2_count", got_cmd.size(), 8);
        if (got_cmd.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t2_byte", got_cmd[i], t2_lit[i]);
            for (int i = 1; i < 8; i++) chk("t2_gap", cmd_cyc_q[i] - cmd_cyc_q[i-1], 2);
            cnt = 0;
            foreach (sloe_hi_q[i])
                if (sloe_hi_q[i] >= rd_cyc_q[0] && sloe_hi_q[i] <= cmd_cyc_q[7]) cnt++;
            chk("t2_sloe_low", cnt, 0);
        end
        chk("t2_fifoadr", fx2_fifoadr, OUT_EP);

        // Reply transmit with turnaround and packet commit
        clear_log();
        s = cyc;
        for (int i = 0; i < 4; i++) push_rep(t3_lit[i], i == 3);
        drain("t3_drain", 100);
        chk("t3_count", got_wr.size(), 4);
        if (got_wr.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("t3_byte", got_wr[i], t3_lit[i]);
                chk("t3_wr_cyc", wr_cyc_q[i], s + 3 + 2 * i);
            end
`ifdef FX2_CMD_PORT_PKTEND_EN
        chk("t3_pk_count", pk_cyc_q.size(), 1);
        if (pk_cyc_q.size() == 1) chk("t3_pk_cyc", pk_cyc_q[0], s + 11);
`else
        chk("t3_pk_count", pk_cyc_q.size(), 0);
`endif
        chk("t3_fifoadr", fx2_fifoadr, IN_EP);

        // Backpressure: IN endpoint full after byte 2
        clear_log();
        base = n_wr;
        for (int i = 0; i < 4; i++) push_rep(t3_lit[i], i == 3);
        k = 0;
        while (n_wr < base + 2 && k < 50) begin tick(); k++; end
        chk("t4_two_written", n_wr - base, 2);
        fx2_in_full_n = 1'b0;
        base = n_wr;
        repeat (10) tick();
        chk("t4_stall_writes", n_wr - base, 0);
        fx2_in_full_n = 1'b1;
        r = cyc;
        k = 0;
        while (n_wr == base && k < 20) begin tick(); k++; end
        chk("t4_resumed", n_wr > base, 1);
        if (n_wr > base) begin
            chk("t4_resume_delay", (wr_cyc_q[2] - r) <= 3, 1);
            chk("t4_byte3", got_wr[2], 8'h34);
        end
        drain("t4_drain", 100);

        // Priority: reply and command arrive together
        clear_log();
        s = cyc;
        for (int i = 0; i < 4; i++) push_cmd(8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) push_rep(t3_lit[i], i == 3);
        drain("t5_drain", 200);
        chk("t5_counts", {16'(wr_cyc_q.size()), 16'(rd_cyc_q.size())}, {16'd4, 16'd4});
        if (wr_cyc_q.size() == 4 && rd_cyc_q.size() == 4) begin
            chk("t5_first_wr_cyc", wr_cyc_q[0], s + 3);
            chk("t5_rd_after_reply", rd_cyc_q[0] > wr_cyc_q[3], 1);
`ifdef FX2_CMD_PORT_PKTEND_EN
            if (pk_cyc_q.size() == 1) chk("t5_rd_after_pktend", rd_cyc_q[0] > pk_cyc_q[0], 1);
`endif
        end

        // Reset in the middle of a read
        for (int i = 0; i < 3; i++) push_cmd(8'h5A + 8'(i));
        k = 0;
        while (fx2_slrd_n && k < 20) begin tick(); k++; end
        chk("t1_in_rd", fx2_slrd_n, 0);
        reset_n = 1'b0;
        #1;
        chk("t1_strobes", {fx2_sloe_n, fx2_slrd_n, fx2_slwr_n, fx2_pktend_n}, 4'hF);
        chk("t1_cmd_wr", cmd_wr, 0);
        chk("t1_ack", reply_ack, 0);
        chk("t1_cmd_in", cmd_in, 0);
        out_q.delete();
        exp_cmd.delete();
        need_pk = 1'b0;
        drive_inputs();
        repeat (3) tick();
        reset_n = 1'b1;
        base = n_rd + n_wr;
        repeat (8) tick();
        chk("t1_stays_idle", n_rd + n_wr - base, 0);
        chk("t1_fifoadr", fx2_fifoadr, OUT_EP);

        // Randomized traffic with flag toggling and reply_rdy drops between bytes
        was_wr = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            tick();
            if ($urandom_range(0, 7) == 0) push_cmd(8'($urandom));
            if (rep_q.size() < 8 && $urandom_range(0, 15) == 0) begin
                k = $urandom_range(1, 5);
                for (int i = 0; i < k; i++) push_rep(8'($urandom), i == k - 1);
            end
            if ($urandom_range(0, 7) == 0) fx2_in_full_n = !fx2_in_full_n;
            if (was_wr && $urandom_range(0, 3) == 0) rdy_en = 1'b0;
            else if (!rdy_en && $urandom_range(0, 2) == 0) rdy_en = 1'b1;
            was_wr = !fx2_slwr_n;
            drive_inputs();
        end
        fx2_in_full_n = 1'b1;
        rdy_en = 1'b1;
        drive_inputs();
        drain("rand_drain", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
